spike_array_seq: RTL and testbench

Batch sequencer for the pipelined spike MAC array (`spike_array_synth`). It accepts a command of the form (base address, batch count) and streams that many weight/activation vectors from the operand RAM into the array, one per cycle. It accumulates the array's 16-bit signed per-batch results into a wide sum and returns that sum through a valid/ready output. It sits between the layer control logic and the array, and owns the array's `start`/`done` handshake.

---
 rtl/spike_seq_pkg.sv | 18 +
 rtl/spike_seq_acc.sv | 66 ++++++
 rtl/spike_array_seq.sv | 123 ++++++++++++
 tb/tb_spike_array_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_seq_pkg.sv
// Shared types and constants for the spike array batch sequencer.
package spike_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_e;

  localparam int ARRAY_LAT = 9;
  localparam int RESULT_W  = 16;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/spike_seq_acc.sv
// Signed accumulator for 16-bit array results, cleared per command.
// Build option SPIKE_SEQ_SAT_EN: saturate at the ACC_W signed bounds and flag a sticky ovf.
module spike_seq_acc
  import spike_seq_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic signed [RESULT_W-1:0] i_val,
  output logic signed [ACC_W-1:0]    o_acc,
  output logic                       o_ovf
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_ext;

  assign w_ext = {{(ACC_W-RESULT_W){i_val[RESULT_W-1]}}, i_val};
  assign o_acc = r_acc;

`ifdef SPIKE_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                  r_ovf;
  logic signed [ACC_W:0] w_sum;
  logic                  w_pos_clamp;
  logic                  w_neg_clamp;

  // One guard bit: a disagreement between the top two bits means the true sum left the range.
  assign w_sum       = {r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext};
  assign w_pos_clamp = !w_sum[ACC_W] && w_sum[ACC_W-1];
  assign w_neg_clamp = w_sum[ACC_W] && !w_sum[ACC_W-1];
  assign o_ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      if (w_pos_clamp) begin
        r_acc <= ACC_MAX;
        r_ovf <= 1'b1;
      end else if (w_neg_clamp) begin
        r_acc <= ACC_MIN;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end
`else
  assign o_ovf = 1'b0;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_ext;
    end
  end
`endif

endmodule

// File: rtl/spike_array_seq.sv
// Batch sequencer: streams operand RAM vectors into the pipelined spike MAC array and sums its results.
// Build option SPIKE_SEQ_SAT_EN selects a saturating sum with sticky out_ovf (wrapping otherwise).
module spike_array_seq
  import spike_seq_pkg::*;
#(
  parameter int N        = 128,
  parameter int BITWIDTH = 4,
  parameter int ADDR_W   = 10,
  parameter int ACC_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_W-1:0]          cmd_base,
  input  logic [ADDR_W:0]            cmd_len,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic [N*4-1:0]             mem_rd_w,
  input  logic [N*BITWIDTH-1:0]      mem_rd_a,
  output logic                       arr_start,
  output logic [N*4-1:0]             arr_weights,
  output logic [N*BITWIDTH-1:0]      arr_acts,
  input  logic                       arr_done,
  input  logic signed [RESULT_W-1:0] arr_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_sum,
  output logic                       out_ovf,
  output logic                       busy
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // ISSUE | one RAM read per cycle; array results retire as they arrive
  // DRAIN | all reads issued; waiting for the remaining array results
  // OUT   | sum held on out_valid until out_ready
  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ST_ISSUE);
  localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);
  localparam logic [1:0] S_OUT   = 2'(ST_OUT);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   r_retired;
  logic              r_arr_start;

  logic              w_accept;
  logic              w_retire;
  logic              w_last_rd;
  logic [ADDR_W:0]   w_retired_nxt;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_accept      = (r_state == S_IDLE) && cmd_valid;
  assign w_retire      = arr_done && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_retired_nxt = r_retired + (ADDR_W+1)'(w_retire);
  assign w_last_rd     = (r_issued + CNT_ONE) == r_len;
  // Truncation to ADDR_W bits gives the wrap from the top of the RAM back to 0.
  assign w_rd_addr     = r_base + r_issued[ADDR_W-1:0];

  assign cmd_ready   = (r_state == S_IDLE) && !rst;
  assign mem_rd_en   = (r_state == S_ISSUE);
  assign mem_rd_addr = mem_rd_en ? w_rd_addr : '0;
  assign arr_start   = r_arr_start;
  assign arr_weights = mem_rd_w;
  assign arr_acts    = mem_rd_a;
  assign out_valid   = (r_state == S_OUT);
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_retired   <= '0;
      r_arr_start <= 1'b0;
    end else begin
      r_arr_start <= mem_rd_en;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_base    <= cmd_base;
            r_len     <= cmd_len;
            r_issued  <= '0;
            r_retired <= '0;
            r_state   <= (cmd_len == '0) ? S_OUT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_issued  <= r_issued + CNT_ONE;
          r_retired <= w_retired_nxt;
          if (w_last_rd) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_retired <= w_retired_nxt;
          if (w_retired_nxt == r_len) r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  spike_seq_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (w_retire),
    .i_val (arr_result),
    .o_acc (out_sum),
    .o_ovf (out_ovf)
  );

endmodule

// File: tb/tb_spike_array_seq.sv
// Self-checking bench for spike_array_seq: RAM and array models plus a per-cycle timeline model.
module tb_spike_array_seq;
  import spike_seq_pkg::*;

  localparam int N     = 128;
  localparam int BW    = 4;
  localparam int AW    = 10;
  localparam int ACC_W = 24;
  localparam int DEPTH = depth_of(AW);
  localparam longint ACC_MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint ACC_MINV = -(64'sd1 <<< (ACC_W-1));

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [AW-1:0]           cmd_base = '0;
  logic [AW:0]             cmd_len = '0;
  logic                    mem_rd_en;
  logic [AW-1:0]           mem_rd_addr;
  logic [N*4-1:0]          mem_rd_w = '0;
  logic [N*BW-1:0]         mem_rd_a = '0;
  logic                    arr_start;
  logic [N*4-1:0]          arr_weights;
  logic [N*BW-1:0]         arr_acts;
  logic                    arr_done;
  logic signed [15:0]      arr_result;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_ovf;
  logic                    busy;
  logic                    inj_done = 1'b0;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] ram_res [DEPTH];

  spike_array_seq #(.N(N), .BITWIDTH(BW), .ADDR_W(AW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_w(mem_rd_w), .mem_rd_a(mem_rd_a), .arr_start(arr_start), .arr_weights(arr_weights),
    .arr_acts(arr_acts), .arr_done(arr_done), .arr_result(arr_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM: one-cycle read latency; the low weight bits carry the batch result, acts carry the address.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_w <= {{(N*4-16){1'b0}}, ram_res[mem_rd_addr]};
      mem_rd_a <= {{(N*BW-AW){1'b0}}, mem_rd_addr};
    end
  end

  // Array: fixed-latency pipeline, cleared by reset.
  logic [ARRAY_LAT-1:0] pv = '0;
  logic signed [15:0]   pr [ARRAY_LAT];
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[ARRAY_LAT-2:0], arr_start};
      pr[0] <= arr_weights[15:0];
      for (int i = 1; i < ARRAY_LAT; i++) pr[i] <= pr[i-1];
    end
  end
  assign arr_done   = pv[ARRAY_LAT-1] | inj_done;
  assign arr_result = inj_done ? 16'sd1000 : pr[ARRAY_LAT-1];

  // Timeline model: expected behaviour in cycle k after a command accepted at cycle 0.
  int      cyc = 0;
  bit      m_active = 0;
  bit      m_after_rst = 0;
  int      m_c0, m_len, m_base;
  longint  m_sum;
  bit      m_ovf;

  function automatic void model_sum(input int base, input int len, output longint s, output bit o);
    longint M;
    s = 0;
    o = 0;
    M = 64'sd1 <<< ACC_W;
    for (int j = 0; j < len; j++) begin
      s += longint'(ram_res[(base + j) % DEPTH]);
`ifdef SPIKE_SEQ_SAT_EN
      if (s > ACC_MAXV) begin s = ACC_MAXV; o = 1; end
      else if (s < ACC_MINV) begin s = ACC_MINV; o = 1; end
`endif
    end
    s = ((s % M) + M) % M;
    if (s > ACC_MAXV) s -= M;
  endfunction

  always @(negedge clk) begin
    int k, ovk, a;
    bit exp_rd, exp_st, exp_ov;
    cyc++;
    if (rst) begin
      chk("cmd_ready_in_rst", cmd_ready, 0);
      m_active    = 0;
      m_after_rst = 1;
    end else begin
      exp_rd = 0; exp_st = 0; exp_ov = 0; a = 0;
      if (m_active) begin
        k      = cyc - m_c0;
        ovk    = (m_len == 0) ? 1 : m_len + ARRAY_LAT + 2;
        exp_rd = (k >= 1) && (k <= m_len);
        exp_st = (k >= 2) && (k <= m_len + 1);
        exp_ov = (k >= ovk);
        if (exp_rd) a = (m_base + k - 1) % DEPTH;
      end
      chk("cmd_ready", cmd_ready, !m_active);
      chk("busy", busy, m_active);
      chk("mem_rd_en", mem_rd_en, exp_rd);
      chk("mem_rd_addr", mem_rd_addr, a);
      chk("arr_start", arr_start, exp_st);
      chk("out_valid", out_valid, exp_ov);
      if (exp_st) begin
        a = (m_base + k - 2) % DEPTH;
        chk("arr_weights", longint'($signed(arr_weights[15:0])), longint'(ram_res[a]));
        chk("arr_acts", longint'(arr_acts[AW-1:0]), a);
      end
      if (exp_ov) begin
        chk("out_sum", longint'(out_sum), m_sum);
        chk("out_ovf", out_ovf, m_ovf);
      end
      if (m_after_rst) begin
        chk("out_sum_after_rst", longint'(out_sum), 0);
        chk("out_ovf_after_rst", out_ovf, 0);
      end
      // model update from inputs sampled for the coming edge
      if (!m_active && cmd_valid) begin
        m_active    = 1;
        m_after_rst = 0;
        m_c0        = cyc;
        m_len       = int'(cmd_len);
        m_base      = int'(cmd_base);
        model_sum(m_base, m_len, m_sum, m_ovf);
      end else if (m_active && exp_ov && out_ready) begin
        m_active = 0;
      end
    end
  end

  task automatic send_cmd(input int base, input int len, input int hold, input bit stray,
                          output int acc_wait, output int lat, output longint sum, output bit ovf);
    bit ok;
    cmd_valid = 1; cmd_base = AW'(base); cmd_len = (AW+1)'(len);
    acc_wait = 0; ok = 0;
    while (!ok && acc_wait < 200) begin
      @(negedge clk); ok = cmd_ready; acc_wait++;
      @(posedge clk); #2;
    end
    cmd_valid = 0;
    if (!ok) chk("cmd_accept_timeout", acc_wait, -1);
    lat = 0; sum = 0; ovf = 0; ok = 0;
    while (!ok && lat < 3000) begin
      @(negedge clk); lat++; ok = out_valid;
      if (!ok) begin @(posedge clk); #2; end
    end
    if (!ok) chk("out_valid_timeout", lat, -1);
    sum = longint'(out_sum);
    ovf = out_ovf;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      inj_done = stray && (i == 5);
    end
    @(posedge clk); #2;
    inj_done = 0; out_ready = 1;
    @(posedge clk); #2;
    out_ready = 0;
  endtask

  initial begin
    int w, lat; longint s; bit o;
    for (int i = 0; i < DEPTH; i++) ram_res[i] = 16'((i * 37) % 201 - 100);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_out_sum", longint'(out_sum), 0);
    @(posedge clk); #2;

    // basic command
    ram_res[0] = 10; ram_res[1] = -3; ram_res[2] = 7; ram_res[3] = 100;
    send_cmd(0, 4, 0, 0, w, lat, s, o);
    chk("basic_latency", lat, 15);
    chk("basic_sum", s, 114);
    chk("basic_ovf", o, 0);

    // zero length
    send_cmd(5, 0, 0, 0, w, lat, s, o);
    chk("zero_latency", lat, 1);
    chk("zero_sum", s, 0);

    // address wrap
    ram_res[1022] = -500; ram_res[1023] = 250;
    send_cmd(1022, 4, 0, 0, w, lat, s, o);
    chk("wrap_sum", s, -243);

    // stray done in IDLE, then backpressure with a stray done in OUT
    inj_done = 1; @(posedge clk); #2; inj_done = 0;
    send_cmd(100, 6, 20, 1, w, lat, s, o);
    chk("bp_latency", lat, 17);
    send_cmd(200, 3, 0, 0, w, lat, s, o);
    chk("bp_next_accept_wait", w, 1);

    // reset mid-DRAIN
    cmd_valid = 1; cmd_base = AW'(300); cmd_len = (AW+1)'(8);
    @(negedge clk); @(posedge clk); #2;
    cmd_valid = 0;
    repeat (11) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_rd_en", mem_rd_en, 0);
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_arr_start", arr_start, 0);
    @(posedge clk); #2;
    send_cmd(10, 2, 0, 0, w, lat, s, o);
    chk("post_rst_sum", s, -26);
    chk("post_rst_latency", lat, 13);

    // full range overflow
    for (int i = 0; i < DEPTH; i++) ram_res[i] = 16'sd8192;
    send_cmd(0, 1024, 0, 0, w, lat, s, o);
    chk("full_latency", lat, 1035);
`ifdef SPIKE_SEQ_SAT_EN
    chk("full_sum", s, 8388607);
    chk("full_ovf", o, 1);
`else
    chk("full_sum", s, -8388608);
    chk("full_ovf", o, 0);
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
